// File: rtl/hrm_multicycle_ctl_pkg.sv
// ---------------------------------------------------------------------------
// hrm_multicycle_ctl_pkg
//   Shared definitions for the HRM multi-cycle sequencer: FSM state encoding,
//   opcode values, ALU / register-R / memory-write mux codes, and the bundled
//   control word driven by the sequencer.
// ---------------------------------------------------------------------------
package hrm_multicycle_ctl_pkg;

   // Sequencer states. Three bits cover all eight states exactly.
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_OPND   = 3'd2,
      S_INDIR  = 3'd3,
      S_PTR    = 3'd4,
      S_MEMRD  = 3'd5,
      S_EXEC   = 3'd6,
      S_HALT   = 3'd7
   } state_t;

   // Opcodes live in instruction bits [7:4]; 12..15 are illegal.
   localparam logic [3:0] OP_INBOX    = 4'd0;
   localparam logic [3:0] OP_OUTBOX   = 4'd1;
   localparam logic [3:0] OP_COPYFROM = 4'd2;
   localparam logic [3:0] OP_COPYTO   = 4'd3;
   localparam logic [3:0] OP_ADD      = 4'd4;
   localparam logic [3:0] OP_SUB      = 4'd5;
   localparam logic [3:0] OP_BUMPUP   = 4'd6;
   localparam logic [3:0] OP_BUMPDN   = 4'd7;
   localparam logic [3:0] OP_JUMP     = 4'd8;
   localparam logic [3:0] OP_JUMPZ    = 4'd9;
   localparam logic [3:0] OP_JUMPN    = 4'd10;
   localparam logic [3:0] OP_HALT     = 4'd11;

   // ALU function codes (3'b100 is PASS in the datapath; the sequencer
   // never selects it).
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_INC = 3'b010;
   localparam logic [2:0] ALU_DEC = 3'b011;

   // Register R source select.
   localparam logic [1:0] MUXR_INBOX = 2'd0;
   localparam logic [1:0] MUXR_MEM   = 2'd1;
   localparam logic [1:0] MUXR_ALU   = 2'd2;

   // Data memory write-data select.
   localparam logic MUXM_R   = 1'b0;
   localparam logic MUXM_ALU = 1'b1;

   // Full set of datapath controls produced each cycle.
   typedef struct packed {
      logic       pc_wr;
      logic       pc_sel;
      logic       ir_wr;
      logic       opnd_wr;
      logic       ptr_wr;
      logic       addr_sel;
      logic [1:0] muxR;
      logic       wR;
      logic       muxM;
      logic       wM;
      logic [2:0] aluCtl;
      logic       inbox_rd;
      logic       outbox_wr;
   } ctl_t;

   // Idle control word: every strobe low, muxR=0, aluCtl=ADD, pc_sel=PC+1.
   localparam ctl_t CTL_IDLE = '0;

endpackage

// File: rtl/hrm_multicycle_ctl_op_decode.sv
// ---------------------------------------------------------------------------
// hrm_multicycle_ctl_op_decode
//   Purely combinational opcode classifier shared by every sequencer state.
//   Ports:
//     opcode     in  4  opcode field (instr[7:4] in DECODE, ir[7:4] later)
//     needs_opnd out 1  an operand byte follows (opcodes 2..10)
//     reads_mem  out 1  data memory is read before execute (2, 4..7)
//     is_jump    out 1  JUMP / JUMPZ / JUMPN (8..10)
//     is_io      out 1  INBOX / OUTBOX (0, 1)
//     illegal    out 1  opcode 12..15
//   HALT (11) raises none of the flags; the caller treats "no operand, not
//   I/O" as a terminal instruction.
// ---------------------------------------------------------------------------
module hrm_multicycle_ctl_op_decode
   import hrm_multicycle_ctl_pkg::*;
(
   input  logic [3:0] opcode,
   output logic       needs_opnd,
   output logic       reads_mem,
   output logic       is_jump,
   output logic       is_io,
   output logic       illegal
);

   always_comb begin
      needs_opnd = 1'b0;
      reads_mem  = 1'b0;
      is_jump    = 1'b0;
      is_io      = 1'b0;
      illegal    = 1'b0;
      case (opcode)
         OP_INBOX, OP_OUTBOX: begin
            is_io = 1'b1;
         end
         OP_COPYFROM, OP_ADD, OP_SUB, OP_BUMPUP, OP_BUMPDN: begin
            needs_opnd = 1'b1;
            reads_mem  = 1'b1;
         end
         OP_COPYTO: begin
            needs_opnd = 1'b1;
         end
         OP_JUMP, OP_JUMPZ, OP_JUMPN: begin
            needs_opnd = 1'b1;
            is_jump    = 1'b1;
         end
         OP_HALT: begin
            // terminal, no operand, no flags
         end
         default: begin
            illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/hrm_multicycle_ctl.sv
// ---------------------------------------------------------------------------
// hrm_multicycle_ctl
//   Multi-cycle sequencer for the HRM CPU. Fetches the instruction byte and
//   the optional operand byte, resolves indirect addressing through the
//   pointer register, then issues one execute cycle (longer while an INBOX /
//   OUTBOX FIFO flag holds it off).
//
//   Parameter:
//     INBOX_EMPTY_HALTS  1: INBOX on empty FIFO halts; 0: stall until data
//   Ports:
//     clk, rst            clock; synchronous active-low reset
//     instr[7:0]          program ROM data
//     zero, neg           R==0 / R<0 flags from the datapath
//     inbox_empty         INBOX FIFO empty
//     outbox_full         OUTBOX FIFO full
//     ir[7:0]             IR contents (registered copy of instr)
//     pc_wr, pc_sel       PC load strobe / 0:PC+1 1:operand
//     ir_wr, opnd_wr      load IR / operand register from instr
//     ptr_wr              load pointer register from memory output
//     addr_sel            data memory address 0:operand 1:pointer
//     muxR[1:0], wR       R source select / R write enable
//     muxM, wM            memory write-data select / memory write enable
//     aluCtl[2:0]         ALU function
//     inbox_rd, outbox_wr FIFO pop / push (one pulse per instruction)
//     halted, illegal     sticky status, cleared only by reset
//
//   Handshake: each FIFO strobe is issued only in a cycle where the matching
//   flag is clear, exactly once, and the FSM leaves EXEC in that same cycle;
//   while the flag is set the FSM waits in EXEC with every strobe low.
// ---------------------------------------------------------------------------
module hrm_multicycle_ctl
   import hrm_multicycle_ctl_pkg::*;
#(
   parameter bit INBOX_EMPTY_HALTS = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] instr,
   input  logic       zero,
   input  logic       neg,
   input  logic       inbox_empty,
   input  logic       outbox_full,
   input  logic [7:0] ir,
   output logic       pc_wr,
   output logic       pc_sel,
   output logic       ir_wr,
   output logic       opnd_wr,
   output logic       ptr_wr,
   output logic       addr_sel,
   output logic [1:0] muxR,
   output logic       wR,
   output logic       muxM,
   output logic       wM,
   output logic [2:0] aluCtl,
   output logic       inbox_rd,
   output logic       outbox_wr,
   output logic       halted,
   output logic       illegal
);

   state_t state_q, state_d;
   logic   halted_q, halted_d;
   logic   illegal_q, illegal_d;
   ctl_t   ctl;
   ctl_t   ctl_out;

   logic [3:0] dec_opcode;
   logic       ind;
   logic       dec_needs_opnd;
   logic       dec_reads_mem;
   logic       dec_is_jump;
   logic       dec_is_io;
   logic       dec_illegal;

   // Low instruction bits are reserved zero and carry no meaning here.
   logic unused_bits;
   assign unused_bits = ^{instr[2:0], ir[2:0]};

   // In DECODE the IR is being loaded this very cycle, so classify the ROM
   // output directly; every later state works from the captured IR.
   assign dec_opcode = (state_q == S_DECODE) ? instr[7:4] : ir[7:4];
   assign ind        = ir[3];

   hrm_multicycle_ctl_op_decode u_op_decode (
      .opcode     (dec_opcode),
      .needs_opnd (dec_needs_opnd),
      .reads_mem  (dec_reads_mem),
      .is_jump    (dec_is_jump),
      .is_io      (dec_is_io),
      .illegal    (dec_illegal)
   );

   // Next-state and control-word logic.
   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q;
      ctl       = CTL_IDLE;

      case (state_q)
         S_FETCH: begin
            // ROM access cycle.
            state_d = S_DECODE;
         end

         S_DECODE: begin
            ctl.ir_wr = 1'b1;
            ctl.pc_wr = 1'b1;
            if (dec_illegal) begin
               illegal_d = 1'b1;
               state_d   = S_HALT;
            end else if (dec_needs_opnd) begin
               state_d = S_OPND;
            end else if (dec_is_io) begin
               state_d = S_EXEC;
            end else begin
               state_d = S_HALT;
            end
         end

         S_OPND: begin
            ctl.opnd_wr = 1'b1;
            ctl.pc_wr   = 1'b1;
            // Indirect bit is meaningful only for memory-addressing
            // instructions; on jumps it is ignored.
            if (ind && !dec_is_jump) begin
               state_d = S_INDIR;
            end else if (dec_reads_mem) begin
               state_d = S_MEMRD;
            end else begin
               state_d = S_EXEC;
            end
         end

         S_INDIR: begin
            // Synchronous read of mem[operand]; data lands in S_PTR.
            ctl.addr_sel = 1'b0;
            state_d      = S_PTR;
         end

         S_PTR: begin
            ctl.ptr_wr = 1'b1;
            state_d    = dec_reads_mem ? S_MEMRD : S_EXEC;
         end

         S_MEMRD: begin
            ctl.addr_sel = ind;
            state_d      = S_EXEC;
         end

         S_EXEC: begin
            ctl.addr_sel = ind;
            state_d      = S_FETCH;
            case (dec_opcode)
               OP_INBOX: begin
                  if (inbox_empty) begin
                     state_d = INBOX_EMPTY_HALTS ? S_HALT : S_EXEC;
                  end else begin
                     ctl.inbox_rd = 1'b1;
                     ctl.wR       = 1'b1;
                     ctl.muxR     = MUXR_INBOX;
                  end
               end
               OP_OUTBOX: begin
                  if (outbox_full) begin
                     state_d = S_EXEC;
                  end else begin
                     ctl.outbox_wr = 1'b1;
                  end
               end
               OP_COPYFROM: begin
                  ctl.muxR = MUXR_MEM;
                  ctl.wR   = 1'b1;
               end
               OP_COPYTO: begin
                  ctl.muxM = MUXM_R;
                  ctl.wM   = 1'b1;
               end
               OP_ADD: begin
                  ctl.aluCtl = ALU_ADD;
                  ctl.muxR   = MUXR_ALU;
                  ctl.wR     = 1'b1;
               end
               OP_SUB: begin
                  ctl.aluCtl = ALU_SUB;
                  ctl.muxR   = MUXR_ALU;
                  ctl.wR     = 1'b1;
               end
               OP_BUMPUP: begin
                  // Incremented value goes to both R and memory.
                  ctl.aluCtl = ALU_INC;
                  ctl.muxR   = MUXR_ALU;
                  ctl.wR     = 1'b1;
                  ctl.muxM   = MUXM_ALU;
                  ctl.wM     = 1'b1;
               end
               OP_BUMPDN: begin
                  ctl.aluCtl = ALU_DEC;
                  ctl.muxR   = MUXR_ALU;
                  ctl.wR     = 1'b1;
                  ctl.muxM   = MUXM_ALU;
                  ctl.wM     = 1'b1;
               end
               OP_JUMP: begin
                  ctl.pc_sel = 1'b1;
                  ctl.pc_wr  = 1'b1;
               end
               OP_JUMPZ: begin
                  if (zero) begin
                     ctl.pc_sel = 1'b1;
                     ctl.pc_wr  = 1'b1;
                  end
               end
               OP_JUMPN: begin
                  if (neg) begin
                     ctl.pc_sel = 1'b1;
                     ctl.pc_wr  = 1'b1;
                  end
               end
               default: begin
                  // Only reachable if IR changed underneath us; stop safely.
                  state_d = S_HALT;
               end
            endcase
         end

         S_HALT: begin
            state_d = S_HALT;
         end

         default: begin
            state_d = S_FETCH;
         end
      endcase

      halted_d = halted_q | (state_d == S_HALT);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_FETCH;
         halted_q  <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         halted_q  <= halted_d;
         illegal_q <= illegal_d;
      end
   end

   // While reset is held nothing may reach the datapath or FIFOs, even
   // though the state register still shows the interrupted instruction.
   assign ctl_out = rst ? ctl : CTL_IDLE;

   assign pc_wr     = ctl_out.pc_wr;
   assign pc_sel    = ctl_out.pc_sel;
   assign ir_wr     = ctl_out.ir_wr;
   assign opnd_wr   = ctl_out.opnd_wr;
   assign ptr_wr    = ctl_out.ptr_wr;
   assign addr_sel  = ctl_out.addr_sel;
   assign muxR      = ctl_out.muxR;
   assign wR        = ctl_out.wR;
   assign muxM      = ctl_out.muxM;
   assign wM        = ctl_out.wM;
   assign aluCtl    = ctl_out.aluCtl;
   assign inbox_rd  = ctl_out.inbox_rd;
   assign outbox_wr = ctl_out.outbox_wr;
   assign halted    = halted_q;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_hrm_multicycle_ctl.sv
// ---------------------------------------------------------------------------
// tb_hrm_multicycle_ctl
//   Bench for hrm_multicycle_ctl. Each instruction is expanded into a
//   per-cycle schedule of inputs and expected outputs from the instruction
//   timing rules (fetch, decode, optional operand / indirect / memory-read
//   cycles, execute with FIFO stalls), then replayed cycle by cycle.
//   A second instance covers INBOX_EMPTY_HALTS=1.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hrm_multicycle_ctl;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, rst_h;
   logic [7:0] instr;
   logic       zero, neg, inbox_empty, outbox_full;
   logic [7:0] ir   = 8'h00;
   logic [7:0] ir_h = 8'h00;

   logic pc_wr, pc_sel, ir_wr, opnd_wr, ptr_wr, addr_sel, wR, muxM, wM;
   logic inbox_rd, outbox_wr, halted, illegal;
   logic [1:0] muxR;
   logic [2:0] aluCtl;

   logic pc_wr_h, pc_sel_h, ir_wr_h, opnd_wr_h, ptr_wr_h, addr_sel_h, wR_h, muxM_h, wM_h;
   logic inbox_rd_h, outbox_wr_h, halted_h, illegal_h;
   logic [1:0] muxR_h;
   logic [2:0] aluCtl_h;

   hrm_multicycle_ctl #(.INBOX_EMPTY_HALTS(1'b0)) dut (
      .clk(clk), .rst(rst), .instr(instr), .zero(zero), .neg(neg),
      .inbox_empty(inbox_empty), .outbox_full(outbox_full), .ir(ir),
      .pc_wr(pc_wr), .pc_sel(pc_sel), .ir_wr(ir_wr), .opnd_wr(opnd_wr),
      .ptr_wr(ptr_wr), .addr_sel(addr_sel), .muxR(muxR), .wR(wR),
      .muxM(muxM), .wM(wM), .aluCtl(aluCtl), .inbox_rd(inbox_rd),
      .outbox_wr(outbox_wr), .halted(halted), .illegal(illegal)
   );

   hrm_multicycle_ctl #(.INBOX_EMPTY_HALTS(1'b1)) dut_h (
      .clk(clk), .rst(rst_h), .instr(instr), .zero(zero), .neg(neg),
      .inbox_empty(inbox_empty), .outbox_full(outbox_full), .ir(ir_h),
      .pc_wr(pc_wr_h), .pc_sel(pc_sel_h), .ir_wr(ir_wr_h), .opnd_wr(opnd_wr_h),
      .ptr_wr(ptr_wr_h), .addr_sel(addr_sel_h), .muxR(muxR_h), .wR(wR_h),
      .muxM(muxM_h), .wM(wM_h), .aluCtl(aluCtl_h), .inbox_rd(inbox_rd_h),
      .outbox_wr(outbox_wr_h), .halted(halted_h), .illegal(illegal_h)
   );

   // Instruction register of the datapath.
   always @(posedge clk) begin
      if (ir_wr === 1'b1)   ir   <= instr;
      if (ir_wr_h === 1'b1) ir_h <= instr;
   end

   // ---------------- observation / expectation ----------------
   typedef struct packed {
      logic       pc_wr;
      logic       pc_sel;
      logic       ir_wr;
      logic       opnd_wr;
      logic       ptr_wr;
      logic       addr_sel;
      logic [1:0] muxR;
      logic       wR;
      logic       muxM;
      logic       wM;
      logic [2:0] aluCtl;
      logic       inbox_rd;
      logic       outbox_wr;
      logic       halted;
      logic       illegal;
   } vec_t;

   typedef struct packed {
      logic       rst;
      logic [7:0] instr;
      logic       ie;
      logic       of;
      logic       z;
      logic       n;
   } stim_t;

   logic [17:0] obs, obs_h;
   assign obs   = {pc_wr, pc_sel, ir_wr, opnd_wr, ptr_wr, addr_sel, muxR, wR, muxM, wM,
                   aluCtl, inbox_rd, outbox_wr, halted, illegal};
   assign obs_h = {pc_wr_h, pc_sel_h, ir_wr_h, opnd_wr_h, ptr_wr_h, addr_sel_h, muxR_h, wR_h,
                   muxM_h, wM_h, aluCtl_h, inbox_rd_h, outbox_wr_h, halted_h, illegal_h};

   stim_t       stim_q[$];
   logic [17:0] exp_q[$];
   int          n_assert = 0;
   int          n_fail   = 0;

   // ---------------- reference model ----------------
   function automatic void push(input stim_t s, input vec_t e);
      stim_q.push_back(s);
      exp_q.push_back(e);
   endfunction

   // Expected controls in the cycle that completes an instruction.
   function automatic vec_t exec_vec(input logic [3:0] op, input logic ind,
                                     input logic z, input logic n);
      vec_t e;
      e = '0;
      e.addr_sel = ind;
      case (op)
         4'd0: begin e.inbox_rd = 1'b1; e.wR = 1'b1; e.muxR = 2'd0; end
         4'd1: e.outbox_wr = 1'b1;
         4'd2: begin e.muxR = 2'd1; e.wR = 1'b1; end
         4'd3: begin e.muxM = 1'b0; e.wM = 1'b1; end
         4'd4: begin e.aluCtl = 3'b000; e.muxR = 2'd2; e.wR = 1'b1; end
         4'd5: begin e.aluCtl = 3'b001; e.muxR = 2'd2; e.wR = 1'b1; end
         4'd6: begin e.aluCtl = 3'b010; e.muxR = 2'd2; e.wR = 1'b1; e.muxM = 1'b1; e.wM = 1'b1; end
         4'd7: begin e.aluCtl = 3'b011; e.muxR = 2'd2; e.wR = 1'b1; e.muxM = 1'b1; e.wM = 1'b1; end
         4'd8: begin e.pc_wr = 1'b1; e.pc_sel = 1'b1; end
         4'd9: begin e.pc_wr = z; e.pc_sel = z; end
         default: begin e.pc_wr = n; e.pc_sel = n; end
      endcase
      return e;
   endfunction

   // Expand one legal instruction (opcode 0..10) into its cycle schedule.
   // FIFO flags are random outside the execute cycle (they must be ignored).
   function automatic void plan_instr(input logic [3:0] op, input logic ind,
                                      input logic [7:0] opnd, input logic z,
                                      input logic n, input int stalls);
      stim_t s;
      vec_t  e;
      s = '{rst: 1'b1, instr: {op, ind, 3'b000}, ie: 1'($urandom), of: 1'($urandom), z: z, n: n};
      e = '0;
      push(s, e);                                   // fetch
      s.ie = 1'($urandom); s.of = 1'($urandom);
      e.ir_wr = 1'b1; e.pc_wr = 1'b1;
      push(s, e);                                   // decode
      if (op >= 4'd2 && op <= 4'd10) begin         // operand byte
         s.instr = opnd; s.ie = 1'($urandom); s.of = 1'($urandom);
         e = '0; e.opnd_wr = 1'b1; e.pc_wr = 1'b1;
         push(s, e);
      end
      if (ind && op >= 4'd2 && op <= 4'd7) begin   // pointer fetch
         s.instr = 8'($urandom); s.ie = 1'($urandom); s.of = 1'($urandom);
         e = '0;
         push(s, e);
         s.instr = 8'($urandom);
         e.ptr_wr = 1'b1;
         push(s, e);
      end
      if (op == 4'd2 || (op >= 4'd4 && op <= 4'd7)) begin
         s.instr = 8'($urandom); s.ie = 1'($urandom); s.of = 1'($urandom);
         e = '0; e.addr_sel = ind;
         push(s, e);
      end
      for (int k = 0; k < stalls; k++) begin       // FIFO holds us off
         s.instr = 8'($urandom);
         s.ie = (op == 4'd0) ? 1'b1 : 1'($urandom);
         s.of = (op == 4'd1) ? 1'b1 : 1'($urandom);
         e = '0; e.addr_sel = ind;
         push(s, e);
      end
      s.instr = 8'($urandom);
      s.ie = (op == 4'd0) ? 1'b0 : 1'($urandom);
      s.of = (op == 4'd1) ? 1'b0 : 1'($urandom);
      push(s, exec_vec(op, ind, z, n));
   endfunction

   // HALT / illegal: decode, then stuck with only the status flags set.
   function automatic void plan_halt(input logic [3:0] op);
      stim_t s;
      vec_t  e;
      s = '{rst: 1'b1, instr: {op, 4'b0000}, ie: 1'b0, of: 1'b0, z: 1'b0, n: 1'b0};
      e = '0;
      push(s, e);
      e.ir_wr = 1'b1; e.pc_wr = 1'b1;
      push(s, e);
      for (int k = 0; k < 3; k++) begin
         s.instr = 8'($urandom); s.ie = 1'($urandom); s.of = 1'($urandom);
         e = '0; e.halted = 1'b1; e.illegal = (op >= 4'd12);
         push(s, e);
      end
   endfunction

   // ---------------- driver / scoreboard ----------------
   // Entered just after a rising edge; drives a cycle, checks mid-cycle.
   task automatic run_sched(input bit use_h, input string tag);
      stim_t       s;
      logic [17:0] e;
      logic [17:0] got;
      int          cyc;
      cyc = 1;
      while (exp_q.size() > 0) begin
         s = stim_q.pop_front();
         e = exp_q.pop_front();
         if (use_h) rst_h = s.rst; else rst = s.rst;
         instr       = s.instr;
         inbox_empty = s.ie;
         outbox_full = s.of;
         zero        = s.z;
         neg         = s.n;
         @(negedge clk);
         got = use_h ? obs_h : obs;
         n_assert++;
         assert (got === e) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, got, e);
         end
         cyc++;
         @(posedge clk); #1;
      end
   endtask

   task automatic reset_all();
      rst = 1'b0; rst_h = 1'b0;
      instr = 8'($urandom); inbox_empty = 1'b0; outbox_full = 1'b0; zero = 1'b0; neg = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      n_assert++;
      assert (obs === 18'h0) else begin
         n_fail++;
         $error("FAIL reset_main: observed %h expected %h", obs, 18'h0);
      end
      n_assert++;
      assert (obs_h === 18'h0) else begin
         n_fail++;
         $error("FAIL reset_halts: observed %h expected %h", obs_h, 18'h0);
      end
      @(posedge clk); #1;
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin : main
      stim_t s;
      vec_t  e;
      logic [3:0] op;
      int stalls;

      reset_all();

      plan_instr(4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 0);
      run_sched(1'b0, "inbox_nostall");

      plan_instr(4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 4);
      run_sched(1'b0, "inbox_stall4");

      plan_instr(4'd1, 1'b0, 8'h00, 1'b0, 1'b0, 2);
      run_sched(1'b0, "outbox_stall2");

      plan_instr(4'd4, 1'b1, 8'h05, 1'b0, 1'b0, 0);
      run_sched(1'b0, "add_ind");

      plan_instr(4'd9, 1'b0, 8'h1A, 1'b1, 1'b0, 0);
      run_sched(1'b0, "jumpz_taken");
      plan_instr(4'd9, 1'b0, 8'h1A, 1'b0, 1'b1, 0);
      run_sched(1'b0, "jumpz_not_taken");
      plan_instr(4'd10, 1'b1, 8'h33, 1'b0, 1'b1, 0);
      run_sched(1'b0, "jumpn_ind_ignored");

      // BUMP+ interrupted by reset in its memory-read cycle, then rerun.
      s = '{rst: 1'b1, instr: 8'h60, ie: 1'b0, of: 1'b0, z: 1'b0, n: 1'b0};
      e = '0;
      push(s, e);
      e.ir_wr = 1'b1; e.pc_wr = 1'b1;
      push(s, e);
      s.instr = 8'h22;
      e = '0; e.opnd_wr = 1'b1; e.pc_wr = 1'b1;
      push(s, e);
      s.rst = 1'b0; s.instr = 8'($urandom);
      e = '0;
      push(s, e);
      plan_instr(4'd6, 1'b0, 8'h22, 1'b0, 1'b0, 0);
      run_sched(1'b0, "bumpup_reset_midway");

      // Random instruction stream.
      for (int i = 0; i < 60; i++) begin
         op     = 4'($urandom_range(0, 10));
         stalls = (op <= 4'd1) ? $urandom_range(0, 3) : 0;
         plan_instr(op, 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), stalls);
         run_sched(1'b0, $sformatf("rand%0d_op%0d", i, op));
      end

      // Illegal and HALT opcodes, each cleared by reset.
      plan_halt(4'd12);
      run_sched(1'b0, "illegal_c0");
      reset_all();
      plan_halt(4'd11);
      run_sched(1'b0, "halt_b0");
      reset_all();
      plan_halt(4'd15);
      run_sched(1'b0, "illegal_f0");
      reset_all();
      plan_instr(4'd2, 1'b1, 8'h07, 1'b0, 1'b0, 0);
      run_sched(1'b0, "copyfrom_after_halt");

      // INBOX_EMPTY_HALTS=1 instance: empty INBOX halts, no pop ever.
      reset_all();
      s = '{rst: 1'b1, instr: 8'h00, ie: 1'b1, of: 1'b0, z: 1'b0, n: 1'b0};
      e = '0;
      push(s, e);
      e.ir_wr = 1'b1; e.pc_wr = 1'b1;
      push(s, e);
      e = '0;
      push(s, e);
      for (int k = 0; k < 3; k++) begin
         s.ie = 1'b0; s.instr = 8'($urandom);
         e = '0; e.halted = 1'b1;
         push(s, e);
      end
      run_sched(1'b1, "halts_inbox_empty");
      reset_all();
      plan_instr(4'd0, 1'b1, 8'h00, 1'b0, 1'b0, 0);
      run_sched(1'b1, "halts_inbox_data");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
